// File: rtl/ddr3_cmd_scheduler.sv
// ddr3_cmd_scheduler: post-init DDR3 sequencer, round-robin closed-page ACT->RD/WR->PRE with periodic REF.
// Define DDR3_AUTO_PRECHARGE_EN to issue RD/WR with auto-precharge and drop the explicit PRE.
module ddr3_cmd_scheduler #(
    parameter int TREFI_CK = 3120,
    parameter int TRFC_CK  = 44,
    parameter int TRCD_CK  = 6,
    parameter int TRP_CK   = 6,
    parameter int TWR_CK   = 12,
    parameter int TRTP_CK  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done_i,
    input  logic [1:0]  req_valid_i,
    input  logic [1:0]  req_we_i,
    input  logic [5:0]  req_bank_i,
    input  logic [27:0] req_row_i,
    input  logic [19:0] req_col_i,
    output logic [1:0]  gnt_o,
    output logic [2:0]  cmd_o,
    output logic [2:0]  ba_o,
    output logic [13:0] addr_o,
    output logic        cas_rd_o,
    output logic        cas_wr_o,
    output logic        cas_id_o,
    output logic        ref_miss_o
);
    localparam logic [2:0] CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR = 3'b100, CMD_RD = 3'b101, CMD_NOP = 3'b111;
    localparam int TW = $clog2(TREFI_CK + 1);
    localparam logic [TW-1:0] TREFI_LD = TW'(TREFI_CK - 1);
`ifdef DDR3_AUTO_PRECHARGE_EN
    localparam logic       AP    = 1'b1;
    localparam logic [7:0] WR_LD = 8'(TWR_CK + TRP_CK - 1);
    localparam logic [7:0] RD_LD = 8'(TRTP_CK + TRP_CK - 1);
`else
    localparam logic       AP    = 1'b0;
    localparam logic [7:0] WR_LD = 8'(TWR_CK - 1);
    localparam logic [7:0] RD_LD = 8'(TRTP_CK - 1);
`endif

    typedef enum logic [2:0] {WAIT_INIT, IDLE, ACT_WAIT, CAS_WAIT, PRE_WAIT, REF_WAIT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          ref_pend_q, ref_pend_d, ref_miss_q, ref_miss_d, last_q, last_d;
    logic          we_q, we_d, id_q, id_d;
    logic [2:0]    bank_q, bank_d;
    logic [9:0]    col_q, col_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [2:0]    cmd_q, cmd_d, ba_q, ba_d;
    logic [13:0]   addr_q, addr_d;
    logic          cas_rd_q, cas_rd_d, cas_wr_q, cas_wr_d, cas_id_q, cas_id_d;
    logic          expire, cnt0, ready, take_ref, win;

    always_comb begin
        expire     = state_q != WAIT_INIT && tmr_q == '0;
        cnt0       = cnt_q == 8'd0;
        // The final wait cycle doubles as IDLE so the next command lands exactly tRP/tRFC later.
        ready      = state_q == IDLE || (cnt0 && (state_q == PRE_WAIT || state_q == REF_WAIT ||
                     (AP && state_q == CAS_WAIT)));
        take_ref   = ready && (ref_pend_q || expire);
        win        = (req_valid_i == 2'b11) ? ~last_q : req_valid_i[1];
        tmr_d      = (state_q == WAIT_INIT || expire) ? TREFI_LD : tmr_q - TW'(1);
        ref_pend_d = take_ref ? (ref_pend_q && expire) : (ref_pend_q || expire);
        ref_miss_d = ref_miss_q || (expire && ref_pend_q);
        state_d    = state_q;
        cnt_d      = cnt0 ? 8'd0 : cnt_q - 8'd1;
        last_d     = last_q;
        we_d       = we_q;
        id_d       = id_q;
        bank_d     = bank_q;
        col_d      = col_q;
        gnt_d      = 2'b00;
        cmd_d      = CMD_NOP;
        ba_d       = ba_q;
        addr_d     = addr_q;
        cas_rd_d   = 1'b0;
        cas_wr_d   = 1'b0;
        cas_id_d   = cas_id_q;
        if (state_q == WAIT_INIT) begin
            if (init_done_i) state_d = IDLE;
        end else if (take_ref) begin
            cmd_d   = CMD_REF;
            cnt_d   = 8'(TRFC_CK - 1);
            state_d = REF_WAIT;
        end else if (ready && req_valid_i != 2'b00) begin
            cmd_d   = CMD_ACT;
            bank_d  = win ? req_bank_i[5:3] : req_bank_i[2:0];
            ba_d    = win ? req_bank_i[5:3] : req_bank_i[2:0];
            addr_d  = win ? req_row_i[27:14] : req_row_i[13:0];
            col_d   = win ? req_col_i[19:10] : req_col_i[9:0];
            we_d    = req_we_i[win];
            gnt_d   = win ? 2'b10 : 2'b01;
            last_d  = win;
            id_d    = win;
            cnt_d   = 8'(TRCD_CK - 1);
            state_d = ACT_WAIT;
        end else if (ready) begin
            state_d = IDLE;
        end else if (cnt0 && state_q == ACT_WAIT) begin
            cmd_d    = we_q ? CMD_WR : CMD_RD;
            ba_d     = bank_q;
            addr_d   = {3'b000, AP, col_q};
            cas_wr_d = we_q;
            cas_rd_d = !we_q;
            cas_id_d = id_q;
            cnt_d    = we_q ? WR_LD : RD_LD;
            state_d  = CAS_WAIT;
        end else if (cnt0 && state_q == CAS_WAIT) begin
            cmd_d   = CMD_PRE;
            ba_d    = bank_q;
            addr_d  = '0;
            cnt_d   = 8'(TRP_CK - 1);
            state_d = PRE_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_INIT;
            cnt_q      <= '0;
            tmr_q      <= '0;
            ref_pend_q <= 1'b0;
            ref_miss_q <= 1'b0;
            last_q     <= 1'b1;
            we_q       <= 1'b0;
            id_q       <= 1'b0;
            bank_q     <= '0;
            col_q      <= '0;
            gnt_q      <= '0;
            cmd_q      <= CMD_NOP;
            ba_q       <= '0;
            addr_q     <= '0;
            cas_rd_q   <= 1'b0;
            cas_wr_q   <= 1'b0;
            cas_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            ref_pend_q <= ref_pend_d;
            ref_miss_q <= ref_miss_d;
            last_q     <= last_d;
            we_q       <= we_d;
            id_q       <= id_d;
            bank_q     <= bank_d;
            col_q      <= col_d;
            gnt_q      <= gnt_d;
            cmd_q      <= cmd_d;
            ba_q       <= ba_d;
            addr_q     <= addr_d;
            cas_rd_q   <= cas_rd_d;
            cas_wr_q   <= cas_wr_d;
            cas_id_q   <= cas_id_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign cmd_o      = cmd_q;
    assign ba_o       = ba_q;
    assign addr_o     = addr_q;
    assign cas_rd_o   = cas_rd_q;
    assign cas_wr_o   = cas_wr_q;
    assign cas_id_o   = cas_id_q;
    assign ref_miss_o = ref_miss_q;
endmodule
